// File: rtl/sm_to_rc_ser.sv
// Bit-serial sign-magnitude to two's complement converter, LSB first.
// Rule: copy bits up to and including the first 1, invert the rest when negative.
module sm_to_rc_ser #(
    parameter int n = 11
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic         SIGN,
    input  logic [n-2:0] MAG,
    output logic [n-1:0] RC,
    output logic         BUSY,
    output logic         DONE
);
    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t         state;
    logic [n-1:0]   opnd;
    logic [n-1:0]   res;
    logic           neg;
    logic           seen;
    logic [CW-1:0]  cnt;
    logic           out_bit;

    // Seen-one only covers bits strictly below the current one, so the first 1 is copied.
    assign out_bit = (neg && seen) ? ~opnd[0] : opnd[0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            opnd  <= '0;
            res   <= '0;
            neg   <= 1'b0;
            seen  <= 1'b0;
            cnt   <= '0;
            RC    <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        opnd  <= {1'b0, MAG};
                        neg   <= SIGN;
                        seen  <= 1'b0;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    res  <= {out_bit, res[n-1:1]};
                    opnd <= opnd >> 1;
                    seen <= seen | opnd[0];
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(n - 1)) begin
                        // Last bit: publish the completed word including this bit.
                        RC    <= {out_bit, res[n-1:1]};
                        DONE  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
